// File: rtl/counter_pkg.sv
// Shared definitions for the mod-N phase counter family.
// The transmitter and this tracker both take their default modulus and marker
// phase from here, so the two sides agree without extra configuration.
package counter_pkg;

  localparam int unsigned DEF_PERIOD     = 8;
  localparam int unsigned DEF_MARK_PHASE = 2;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  // Phase to load on the cycle after a marker edge: the edge cycle itself is
  // taken to be the marker phase.
  function automatic int unsigned realign_phase(input int unsigned period,
                                                input int unsigned mark_phase);
    return (mark_phase + 1) % period;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for the marker line.
// Ports:
//   clock    - rising-edge clock
//   reset_n  - asynchronous active-low reset
//   pulse_in - raw marker line
//   rise     - high for the cycle where pulse_in is 1 and was 0 last cycle
// The history register updates every cycle regardless of any freeze, so a
// line that rose during a freeze never produces a late edge.
module rise_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic pulse_in,
  output logic rise
);

  logic pulse_prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pulse_prev <= 1'b0;
    end else begin
      pulse_prev <= pulse_in;
    end
  end

  assign rise = pulse_in & ~pulse_prev;

endmodule

// File: rtl/counter_phase_tracker.sv
// Receive-side phase tracker for the stoppable mod-PERIOD phase counter.
// Recovers the transmitter phase from its once-per-revolution marker, declares
// lock after LOCK_COUNT consecutive on-phase markers, flags slips while locked
// and regenerates a local marker.
// Ports:
//   clock    - rising-edge clock
//   reset_n  - asynchronous active-low reset
//   pulse_in - marker line from the transmitter
//   stop     - shared freeze (1 = transmitter counter held)
//   phase    - recovered phase (registered)
//   locked   - lock indicator (registered)
//   mark     - regenerated marker, combinational from registers and stop
//   err      - one-cycle slip flag (registered)
module counter_phase_tracker
  import counter_pkg::*;
#(
  parameter  int unsigned PERIOD     = DEF_PERIOD,
  parameter  int unsigned MARK_PHASE = DEF_MARK_PHASE,
  parameter  int unsigned LOCK_COUNT = 3,
  parameter  int unsigned MISS_LIMIT = 2,
  localparam int unsigned PW         = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          pulse_in,
  input  logic          stop,
  output logic [PW-1:0] phase,
  output logic          locked,
  output logic          mark,
  output logic          err
);

  localparam int unsigned MW  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned SW  = $clog2(MISS_LIMIT + 1);

  localparam logic [PW-1:0] LAST_PH  = PW'(PERIOD - 1);
  localparam logic [PW-1:0] MARK_PH  = PW'(MARK_PHASE);
  localparam logic [PW-1:0] ALIGN_PH = PW'(realign_phase(PERIOD, MARK_PHASE));
  localparam logic [MW-1:0] LOCK_N   = MW'(LOCK_COUNT);
  localparam logic [SW-1:0] MISS_N   = SW'(MISS_LIMIT);

  state_t        state_q, state_d;
  logic [PW-1:0] phase_d, phase_adv;
  logic [MW-1:0] match_q, match_d, match_inc;
  logic [SW-1:0] miss_q, miss_d, miss_inc;
  logic          err_d;
  logic          rise;
  logic          mark_cyc;

  rise_detect u_rise (
    .clock    (clock),
    .reset_n  (reset_n),
    .pulse_in (pulse_in),
    .rise     (rise)
  );

  assign phase_adv = (phase == LAST_PH) ? '0 : phase + 1'b1;
  assign mark_cyc  = (phase == MARK_PH);
  assign match_inc = match_q + 1'b1;
  assign miss_inc  = miss_q + 1'b1;

  always_comb begin
    state_d = state_q;
    phase_d = phase;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;

    // A frozen cycle holds everything; the edge history still advances in
    // rise_detect.
    if (!stop) begin
      phase_d = phase_adv;
      case (state_q)
        SEARCH: begin
          if (rise) begin
            phase_d = ALIGN_PH;
            match_d = MW'(1);
            miss_d  = '0;
            state_d = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          if (rise && mark_cyc) begin
            match_d = match_inc;
            if (match_inc == LOCK_N) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else if (rise) begin
            phase_d = ALIGN_PH;
            match_d = MW'(1);
          end else if (mark_cyc) begin
            state_d = SEARCH;
            match_d = '0;
          end
        end
        LOCKED: begin
          // Phase free-runs while locked; a misplaced edge and a missing
          // marker are each one miss, and they can never share a cycle.
          if (rise && mark_cyc) begin
            miss_d = '0;
          end else if (rise || mark_cyc) begin
            err_d = 1'b1;
            if (miss_inc == MISS_N) begin
              state_d = SEARCH;
              miss_d  = '0;
              match_d = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: begin
          state_d = SEARCH;
          match_d = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEARCH;
      phase   <= '0;
      match_q <= '0;
      miss_q  <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      phase   <= phase_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      locked  <= (state_d == LOCKED);
      err     <= err_d;
    end
  end

  assign mark = locked & ~stop & (phase == MARK_PH);

endmodule
